// File: rtl/vga_timing_pkg.sv
// Shared XGA 1024x768@60 timing constants for the generator and the drawing stages.
// Screen-edge tests downstream should use these names rather than literals.
package vga_timing_pkg;

    localparam int CNT_W       = 12;
    localparam int FRAME_CNT_W = 16;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;

    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;

    function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus sync/blank flags registered from the
// next-count value, so flags never lag the count they describe.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL      = H_TOTAL,
    parameter int ACTIVE     = H_ACTIVE,
    parameter int SYNC_START = HS_START,
    parameter int SYNC_END   = HS_END
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             blnk,
    output logic             wrap
);

    localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C     = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START_C = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] SYNC_END_C   = CNT_W'(SYNC_END);
    localparam logic [CNT_W-1:0] ONE_C        = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic             sync_q, sync_d;
    logic             blnk_q, blnk_d;

    always_comb begin
        wrap    = step && (count_q == LAST_C);
        count_d = count_q;
        sync_d  = sync_q;
        blnk_d  = blnk_q;
        if (step) begin
            count_d = wrap ? '0 : count_q + ONE_C;
            // Flags follow the value being loaded, not the one being left.
            blnk_d  = (count_d >= ACTIVE_C);
            sync_d  = (count_d >= SYNC_START_C) && (count_d <= SYNC_END_C);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sync_q  <= 1'b0;
            blnk_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            sync_q  <= sync_d;
            blnk_q  <= blnk_d;
        end
    end

    assign count = count_q;
    assign sync  = sync_q;
    assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Source of the VGA timing bus: counts, syncs, blanks and a frame-start strobe.
// Define VGA_FRAME_CNT_EN to add a 16-bit frame_cnt output.
module vga_timing_gen #(
    parameter int H_ACTIVE = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP     = vga_timing_pkg::H_FP,
    parameter int H_SYNC   = vga_timing_pkg::H_SYNC,
    parameter int H_BP     = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP     = vga_timing_pkg::V_FP,
    parameter int V_SYNC   = vga_timing_pkg::V_SYNC,
    parameter int V_BP     = vga_timing_pkg::V_BP
) (
    input  logic                             clk_in,
    input  logic                             rst_n,
    input  logic                             en,
    output logic [vga_timing_pkg::CNT_W-1:0] hcount_out,
    output logic                             hsync_out,
    output logic                             hblnk_out,
    output logic [vga_timing_pkg::CNT_W-1:0] vcount_out,
    output logic                             vsync_out,
    output logic                             vblnk_out,
    output logic                             frame_start
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [vga_timing_pkg::FRAME_CNT_W-1:0] frame_cnt
`endif
);

    import vga_timing_pkg::CNT_W;
    import vga_timing_pkg::FRAME_CNT_W;
    import vga_timing_pkg::axis_total;

    localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    logic h_wrap;
    logic v_wrap;
    logic frame_start_q, frame_start_d;

    vga_axis_counter #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (HS_START),
        .SYNC_END   (HS_END)
    ) u_h_axis (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .step   (en),
        .count  (hcount_out),
        .sync   (hsync_out),
        .blnk   (hblnk_out),
        .wrap   (h_wrap)
    );

    // h_wrap already includes en, so the line advances only on an enabled wrap.
    vga_axis_counter #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (VS_START),
        .SYNC_END   (VS_END)
    ) u_v_axis (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .step   (h_wrap),
        .count  (vcount_out),
        .sync   (vsync_out),
        .blnk   (vblnk_out),
        .wrap   (v_wrap)
    );

    always_comb begin
        frame_start_d = h_wrap && v_wrap;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    // Bumped on the same edge that raises frame_start, wrapping naturally.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_start_d) begin
            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size XGA instance for line-level timing, plus a tiny
// 16x10 instance so whole frames fit in a short run.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n = 1'b1;
    logic en_a    = 1'b0;
    logic rst_b_n = 1'b1;
    logic en_b    = 1'b0;

    logic [11:0] hc_a, vc_a, hc_b, vc_b;
    logic        hs_a, hb_a, vs_a, vb_a, fs_a;
    logic        hs_b, hb_b, vs_b, vb_b, fs_b;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] fc_a, fc_b;
`endif

    int checks = 0;
    int errors = 0;

    vga_timing_gen dut_a (
        .clk_in      (clk),
        .rst_n       (rst_a_n),
        .en          (en_a),
        .hcount_out  (hc_a),
        .hsync_out   (hs_a),
        .hblnk_out   (hb_a),
        .vcount_out  (vc_a),
        .vsync_out   (vs_a),
        .vblnk_out   (vb_a),
        .frame_start (fs_a)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_a)
`endif
    );

    // Small geometry: H 8+2+3+3=16 (hsync 10..12), V 6+1+2+1=10 (vsync 7..8).
    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1)
    ) dut_b (
        .clk_in      (clk),
        .rst_n       (rst_b_n),
        .en          (en_b),
        .hcount_out  (hc_b),
        .hsync_out   (hs_b),
        .hblnk_out   (hb_b),
        .vcount_out  (vc_b),
        .vsync_out   (vs_b),
        .vblnk_out   (vb_b),
        .frame_start (fs_b)
`ifdef VGA_FRAME_CNT_EN
        ,
        .frame_cnt   (fc_b)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero_a(input string tag);
        check({tag, "_h"},  32'(hc_a), 0);
        check({tag, "_v"},  32'(vc_a), 0);
        check({tag, "_hs"}, 32'(hs_a), 0);
        check({tag, "_hb"}, 32'(hb_a), 0);
        check({tag, "_vs"}, 32'(vs_a), 0);
        check({tag, "_vb"}, 32'(vb_a), 0);
        check({tag, "_fs"}, 32'(fs_a), 0);
    endtask

    initial begin
        int exp_h, exp_v, hs_len, fs_seen, mh, mv, frames, exp_fs;

        // ---- reset values, no clock edge yet ----
        #2 rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        #1 check_all_zero_a("reset");
        $display("phase reset: checks=%0d", checks);

        // ---- one full line on the XGA instance ----
        @(negedge clk);
        rst_a_n = 1'b1;
        en_a    = 1'b1;
        hs_len  = 0;
        fs_seen = 0;
        for (int k = 1; k <= 1344; k++) begin
            @(posedge clk); #1;
            exp_h = k % 1344;
            exp_v = (k == 1344) ? 1 : 0;
            check("line_h",  32'(hc_a), 32'(exp_h));
            check("line_v",  32'(vc_a), 32'(exp_v));
            check("line_hb", 32'(hb_a), 32'(exp_h >= 1024));
            check("line_hs", 32'(hs_a), 32'(exp_h >= 1048 && exp_h <= 1183));
            check("line_vb", 32'(vb_a), 0);
            if (hs_a) hs_len++;
            if (fs_a) fs_seen++;
        end
        check("hsync_len", 32'(hs_len), 136);
        check("line_no_fs", 32'(fs_seen), 0);
        $display("phase line: checks=%0d errors=%0d", checks, errors);

        // ---- freeze at hcount 1047 on line 1 ----
        repeat (1047) @(posedge clk);
        #1;
        check("pre_freeze_h",  32'(hc_a), 1047);
        check("pre_freeze_hs", 32'(hs_a), 0);
        en_a = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            check("freeze_h",  32'(hc_a), 1047);
            check("freeze_v",  32'(vc_a), 1);
            check("freeze_hs", 32'(hs_a), 0);
            check("freeze_hb", 32'(hb_a), 1);
            check("freeze_fs", 32'(fs_a), 0);
        end
        en_a = 1'b1;
        @(posedge clk); #1;
        check("resume_h",  32'(hc_a), 1048);
        check("resume_hs", 32'(hs_a), 1);
        check("resume_v",  32'(vc_a), 1);
        $display("phase freeze: checks=%0d errors=%0d", checks, errors);

        // ---- asynchronous reset mid-frame at (700, 2) ----
        repeat (996) @(posedge clk);
        #1;
        check("pre_rst_h", 32'(hc_a), 700);
        check("pre_rst_v", 32'(vc_a), 2);
        #2 rst_a_n = 1'b0;
        #1 check_all_zero_a("async_rst");
        @(negedge clk);
        rst_a_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_h",  32'(hc_a), 1);
        check("post_rst_v",  32'(vc_a), 0);
        check("post_rst_fs", 32'(fs_a), 0);
        check("post_rst_hb", 32'(hb_a), 0);
        en_a = 1'b0;
        $display("phase async_reset: checks=%0d errors=%0d", checks, errors);

        // ---- small instance: three frames with en gaps ----
        @(negedge clk);
        rst_b_n = 1'b1;
        mh      = 0;
        mv      = 0;
        frames  = 0;
        for (int cyc = 0; cyc < 2000 && frames < 3; cyc++) begin
            en_b = ((cyc % 7) != 3);
            @(posedge clk); #1;
            exp_fs = 0;
            if (en_b) begin
                if (mh == 15) begin
                    mh = 0;
                    if (mv == 9) begin
                        mv     = 0;
                        exp_fs = 1;
                    end else begin
                        mv++;
                    end
                end else begin
                    mh++;
                end
            end
            check("frm_h",  32'(hc_b), 32'(mh));
            check("frm_v",  32'(vc_b), 32'(mv));
            check("frm_hb", 32'(hb_b), 32'(mh >= 8));
            check("frm_hs", 32'(hs_b), 32'(mh >= 10 && mh <= 12));
            check("frm_vb", 32'(vb_b), 32'(mv >= 6));
            check("frm_vs", 32'(vs_b), 32'(mv >= 7 && mv <= 8));
            check("frm_fs", 32'(fs_b), 32'(exp_fs));
            if (fs_b) frames++;
        end
        check("frame_count", 32'(frames), 3);
        $display("phase frames: checks=%0d errors=%0d", checks, errors);

`ifdef VGA_FRAME_CNT_EN
        check("frame_cnt_3", 32'(fc_b), 3);
        en_b = 1'b1;
        force dut_b.frame_cnt_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut_b.frame_cnt_q;
        check("frame_cnt_forced", 32'(fc_b), 32'hFFFF);
        begin
            int waited;
            waited = 0;
            while (!fs_b && waited < 400) begin
                @(posedge clk); #1;
                waited++;
            end
            check("frame_cnt_wait", 32'(fs_b), 1);
        end
        check("frame_cnt_wrap", 32'(fc_b), 0);
        $display("phase frame_cnt: checks=%0d errors=%0d", checks, errors);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Source end of the VGA timing bus: generates hcount/vcount, hsync/vsync and hblnk/vblnk for the 1024x768 @ 60 Hz (XGA, 65 MHz pixel clock) pipeline.
- Drives the first drawing stage directly. Every downstream stage registers and forwards these signals unchanged.
- Also emits a one-cycle frame-start strobe. Game-logic blocks use it to update puck and paddle positions once per frame.

Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch in pixels
- H_SYNC, 136, hsync width in pixels
- H_BP, 160, horizontal back porch in pixels (H_TOTAL = 1344)
- V_ACTIVE, 768, visible lines per frame
- V_FP, 3, vertical front porch in lines
- V_SYNC, 6, vsync width in lines
- V_BP, 29, vertical back porch in lines (V_TOTAL = 806)

Ports:
- clk_in  input  1  pixel clock, 65 MHz
- rst_n  input  1  asynchronous active-low reset
- en  input  1  advance enable; when low the whole timing state freezes
- hcount_out  output  12  horizontal pixel index, 0..H_TOTAL-1
- hsync_out  output  1  horizontal sync, active-high
- hblnk_out  output  1  horizontal blanking, active-high
- vcount_out  output  12  line index, 0..V_TOTAL-1
- vsync_out  output  1  vertical sync, active-high
- vblnk_out  output  1  vertical blanking, active-high
- frame_start  output  1  one-cycle pulse when the outputs enter (0,0)

Behaviour:
- All outputs are flops. No combinational path from any input to any output.
- Reset (rst_n low, asynchronous):
  - hcount_out = 0, vcount_out = 0.
  - hsync_out, hblnk_out, vsync_out, vblnk_out = 0.
  - frame_start = 0.
- Flags are derived from the next-count values. The flags are therefore always consistent with the count presented in the same cycle: zero skew between count and flags.
- Horizontal counter, per enabled cycle:
  - hcount = H_TOTAL-1 wraps to 0; otherwise hcount increments by 1.
- Vertical counter:
  - Advances only in the cycle where hcount wraps.
  - vcount = V_TOTAL-1 wraps to 0; otherwise vcount increments by 1.
- Horizontal flags:
  - hblnk = (hcount >= H_ACTIVE), i.e. 1024..1343.
  - hsync = (H_ACTIVE+H_FP <= hcount <= H_ACTIVE+H_FP+H_SYNC-1), i.e. 1048..1183.
- Vertical flags:
  - vblnk = (vcount >= V_ACTIVE), i.e. 768..805.
  - vsync = (V_ACTIVE+V_FP <= vcount <= V_ACTIVE+V_FP+V_SYNC-1), i.e. 771..776.
  - Vertical flags are full-line quantities and change only together with a vcount change (hcount = 0).
- frame_start:
  - High for exactly one cycle, in the cycle where the outputs show hcount = 0, vcount = 0 as the result of an enabled wrap from (1343,805).
  - Not asserted by reset release itself: the first pulse comes after the first complete frame.
- en low:
  - All counts and flags hold their values; frame_start is 0.
  - Re-enabling resumes from the held position with no skipped or repeated count.
- Reset mid-frame: immediate return to reset values. The next enabled cycle outputs hcount = 1, vcount = 0.
- Width rule: counters are 12 bits. Comparisons use unsigned 12-bit arithmetic and the full-width constants from the package.

Optional Feature:
- Macro: VGA_FRAME_CNT_EN.
- When defined:
  - An extra output port frame_cnt (16 bits) is present.
  - Reset value 0.
  - Increments in the same cycle frame_start is asserted; wraps 65535 -> 0.
  - Used for blink and animation timing.
- When not defined: the port and its register are absent; all other behaviour is identical.

Decomposition:
- Shared package vga_timing_pkg:
  - All eight porch/sync/active constants.
  - Derived H_TOTAL, V_TOTAL, HS_START, HS_END, VS_START, VS_END.
  - Same constants used by the drawing stages for screen-edge tests.
- One sub-module, vga_axis_counter:
  - Parameterised by TOTAL, ACTIVE, SYNC_START, SYNC_END.
  - Inputs: clk_in, rst_n, step.
  - Outputs: count, sync, blnk, wrap.
  - Instantiated twice: horizontal with step = en; vertical with step = horizontal wrap & en.

Test Plan:
- Reset, then en = 1 for 1344 cycles -> hcount runs 0..1343 and returns to 0; vcount steps 0 -> 1 exactly at that wrap; hblnk rises at hcount = 1024; hsync high for exactly 136 cycles, 1048..1183.
- Run one full frame (1344*806 = 1,083,264 enabled cycles) -> exactly one frame_start, coincident with (0,0); vsync high for 6 lines, 771..776; vblnk high for 38 lines, 768..805.
- Hold en = 0 for 50 cycles at hcount = 1047 -> all outputs frozen, frame_start = 0; on re-enable the next hcount is 1048 and hsync rises in the same cycle.
- Assert rst_n low asynchronously at vcount = 400, hcount = 700 -> outputs go to 0 without waiting for a clock edge; after release the first enabled edge gives hcount = 1, vcount = 0, and there is no frame_start.
- With VGA_FRAME_CNT_EN defined, run 3 frames -> frame_cnt = 3. Force frame_cnt to 65535 and complete a frame -> frame_cnt = 0.
- Every cycle of one frame, check hblnk == (hcount >= 1024) and vblnk == (vcount >= 768) in the same cycle -> zero mismatches.
